ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute-to-memory boundary register placed directly downstream of the ALU.
- Captures the ALU result and Z/N/C/V flags together with the instruction's control fields.
- Resolves conditional branches and jumps from the flags and issues a one-cycle redirect to fetch.
- Decouples execute from memory with a 2-entry skid buffer on a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  stage can accept; registered
alu_o  in  XLEN  ALU result
alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags; ALU set to subtract for branches, so C=1 means borrow (A<B unsigned)
rd  in  REG_AW  destination register
reg_write  in  1  writes rd
mem_read, mem_write  in  1 each  load/store
mem_size  in  3  funct3 of load/store, passed through
store_data  in  XLEN  rs2 value for stores
is_branch  in  1  conditional branch
is_jump  in  1  JAL/JALR
br_funct3  in  3  BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111
target  in  XLEN  branch/jump target
pc_plus4  in  XLEN  link value
flush  in  1  kill all held entries
out_valid  out  1  entry available to memory stage
out_ready  in  1  memory stage accepts
out_result, out_store_data  out  XLEN each  result (link value for jumps), store data
out_rd  out  REG_AW  destination
out_reg_write, out_mem_read, out_mem_write  out  1 each  controls
out_mem_size  out  3  passed through
out_misalign  out  1  taken target misaligned
redirect_valid  out  1  one-cycle pulse
redirect_pc  out  XLEN  new fetch address

Behaviour:
- Reset: all out_* outputs, redirect_valid and redirect_pc are 0. Both entries are invalid. in_ready=1.
- Storage: main entry drives the out_* ports. The skid entry holds overflow.
- in_ready = !skid_valid, registered.
- Accept when in_valid && in_ready. Drain when out_valid && out_ready.
- Routing on accept:
  - Main empty or draining this cycle: the incoming entry loads main, or loads skid if skid is occupied, preserving order.
  - Otherwise the incoming entry loads skid.
  - On drain with skid valid, skid moves to main the same cycle.
- Throughput: steady-state 1 instruction/cycle. Latency in→out is 1 cycle.
- Taken condition:
  - EQ=Z, NE=!Z.
  - LT=N^V, GE=!(N^V).
  - LTU=C, GEU=!C.
  - br_funct3 values 010/011 give not-taken.
  - is_jump is always taken.
- Jump result: for jumps, out_result=pc_plus4; otherwise out_result=alu_o.
- Misaligned target: if taken and target[1:0]!=0:
  - out_misalign=1, out_reg_write=0, out_mem_read=0, out_mem_write=0;
  - no redirect is issued.
- reg_write with rd==0 is forced to 0.
- Redirect: on an accepted, taken, aligned instruction, redirect_valid=1 and redirect_pc=target on the next cycle for exactly one cycle. This holds independent of out_ready. redirect_pc holds its last value otherwise.
- Flush is synchronous:
  - It clears both entries and suppresses any redirect from an instruction accepted that cycle.
  - flush and accept in the same cycle: flush wins and the incoming instruction is dropped.
  - flush and drain in the same cycle: the drain completes, then the entries clear.
- Mid-operation reset: everything returns to reset values immediately (asynchronous), including an in-flight redirect pulse.
- Invariants:
  - out_valid=0 implies skid empty.
  - Order is preserved.
  - No entry is duplicated or lost except through flush.

Decomposition:
- Shared package:
  - branch funct3 encodings;
  - XLEN/REG_AW defaults;
  - the entry struct typedef (result, store_data, rd, controls, mem_size, misalign).
- One natural sub-module: branch_cond, the combinational flags+funct3+is_jump → taken, misalign logic. It is reused by any future early-branch unit.

Test Plan:
- BEQ with alu_z=1, target=0x100 → next cycle redirect_valid=1 for one cycle, redirect_pc=0x100. out_valid=1, out_reg_write=0.
- BLT with N=1, V=1 → not taken, no redirect. BLTU with C=1 → taken.
- JAL rd=1, pc_plus4=0x24, target=0x40 → out_result=0x24, out_reg_write=1, redirect to 0x40. The same instruction with rd=0 gives out_reg_write=0.
- out_ready held 0 for 3 cycles while issuing instructions A, B, C:
  - A is in main and B in skid; in_ready=0 after B, so C waits.
  - Release out_ready: order A, B, C is delivered with no bubbles.
- Taken jump to 0x102 → out_misalign=1, all write controls 0, no redirect.
- flush asserted with skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, redirect_valid=0. rst_n pulsed low mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the execute/memory boundary and branch resolution.
package ex_mem_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Entry fields are sized by the package defaults; the stage parameters must match them.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   result;
    logic [XLEN_DEF-1:0]   store_data;
    logic [REG_AW_DEF-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_size;
    logic                  misalign;
  } entry_t;

endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// Resolves taken/not-taken from subtract flags and funct3, and flags misaligned taken targets.
module ex_mem_stage_branch_cond
  import ex_mem_pkg::*;
(
  input  logic       is_branch,
  input  logic       is_jump,
  input  logic [2:0] funct3,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [1:0] target_lo,
  output logic       taken,
  output logic       misalign
);

  logic cond;

  // C is a borrow flag here, so LTU is simply C.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = alu_z;
      F3_BNE:  cond = !alu_z;
      F3_BLT:  cond = alu_n ^ alu_v;
      F3_BGE:  cond = !(alu_n ^ alu_v);
      F3_BLTU: cond = alu_c;
      F3_BGEU: cond = !alu_c;
      default: cond = 1'b0;
    endcase
  end

  assign taken    = is_jump | (is_branch & cond);
  assign misalign = taken & (target_lo != 2'b00);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory boundary: 2-entry skid buffer, branch/jump resolution and one-cycle fetch redirect.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_o,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_size,
  input  logic [XLEN-1:0]   store_data,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic [2:0]        br_funct3,
  input  logic [XLEN-1:0]   target,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [2:0]        out_mem_size,
  output logic              out_misalign,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  entry_t            main_q, main_d, skid_q, skid_d, in_entry;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              taken, misalign;
  logic              accept, drain;

  ex_mem_stage_branch_cond u_branch_cond (
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .funct3    (br_funct3),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_c     (alu_c),
    .alu_v     (alu_v),
    .target_lo (target[1:0]),
    .taken     (taken),
    .misalign  (misalign)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = main_valid_q && out_ready;

  // A misaligned taken target turns the instruction into a side-effect-free trap carrier.
  always_comb begin
    in_entry            = '0;
    in_entry.result     = is_jump ? pc_plus4 : alu_o;
    in_entry.store_data = store_data;
    in_entry.rd         = rd;
    in_entry.reg_write  = reg_write && (rd != '0) && !misalign;
    in_entry.mem_read   = mem_read && !misalign;
    in_entry.mem_write  = mem_write && !misalign;
    in_entry.mem_size   = mem_size;
    in_entry.misalign   = misalign;
  end

  always_comb begin
    main_d           = main_q;
    main_valid_d     = main_valid_q;
    skid_d           = skid_q;
    skid_valid_d     = skid_valid_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // in_ready is !skid_valid, so an accepted entry always finds the skid free.
    if (accept && !flush) begin
      if (!main_valid_d) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
      if (taken && !misalign) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = target;
      end
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q           <= '0;
      main_valid_q     <= 1'b0;
      skid_q           <= '0;
      skid_valid_q     <= 1'b0;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      main_q           <= main_d;
      main_valid_q     <= main_valid_d;
      skid_q           <= skid_d;
      skid_valid_q     <= skid_valid_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_valid_q;
  assign out_result     = main_q.result;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_mem_size   = main_q.mem_size;
  assign out_misalign   = main_q.misalign;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: branch resolution, redirect pulse, skid ordering, flush and async reset.
module tb_ex_mem_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_o;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic [2:0]  mem_size;
  logic [31:0] store_data;
  logic        is_branch, is_jump;
  logic [2:0]  br_funct3;
  logic [31:0] target, pc_plus4;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [2:0]  out_mem_size;
  logic        out_misalign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vecs = 0;
  int miscompares = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .store_data(store_data), .is_branch(is_branch),
    .is_jump(is_jump), .br_funct3(br_funct3), .target(target), .pc_plus4(pc_plus4),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
    .out_misalign(out_misalign), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; alu_o = 0; alu_z = 0; alu_n = 0; alu_c = 0; alu_v = 0;
    rd = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_size = 0;
    store_data = 0; is_branch = 0; is_jump = 0; br_funct3 = 0;
    target = 0; pc_plus4 = 0; flush = 0;
  endtask

  task automatic drive(input logic br, input logic jmp, input logic [2:0] f3,
                       input logic z, input logic n, input logic c, input logic v,
                       input logic [31:0] alu, input logic [31:0] tgt,
                       input logic [31:0] pc4, input logic [4:0] r, input logic rw);
    in_valid = 1; is_branch = br; is_jump = jmp; br_funct3 = f3;
    alu_z = z; alu_n = n; alu_c = c; alu_v = v; alu_o = alu; target = tgt;
    pc_plus4 = pc4; rd = r; reg_write = rw; mem_read = 0; mem_write = 0;
    mem_size = 3'b010; store_data = alu ^ 32'h0000_ffff;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1; idle();
    #12;
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_redirect got %0b/%h want 0/0", redirect_valid, redirect_pc); end
    vecs++; if (out_result !== 32'h0 || out_reg_write !== 1'b0 || out_misalign !== 1'b0 || out_rd !== 5'd0) begin miscompares++; $display("FAIL reset_outputs got res=%h rw=%0b mis=%0b rd=%0d want zeros", out_result, out_reg_write, out_misalign, out_rd); end
    rst_n = 1;
    step();
  endtask

  task automatic test_beq();
    drive(1, 0, 3'b000, 1, 0, 0, 0, 32'h0, 32'h100, 32'h8, 5'd0, 0);
    step(); idle();
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL beq_redirect got %0b/%h want 1/00000100", redirect_valid, redirect_pc); end
    vecs++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0) begin miscompares++; $display("FAIL beq_out got v=%0b rw=%0b want 1/0", out_valid, out_reg_write); end
    step();
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h100) begin miscompares++; $display("FAIL beq_pulse_end got %0b/%h want 0/00000100", redirect_valid, redirect_pc); end
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL beq_drained got %0b want 0", out_valid); end
  endtask

  task automatic test_cond();
    drive(1, 0, 3'b100, 0, 1, 0, 1, 32'h11, 32'h200, 32'h0, 5'd0, 0);
    step();
    vecs++; if (redirect_valid !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h11) begin miscompares++; $display("FAIL blt_nv got rv=%0b v=%0b res=%h want 0/1/00000011", redirect_valid, out_valid, out_result); end
    drive(1, 0, 3'b110, 0, 0, 1, 0, 32'h22, 32'h200, 32'h0, 5'd0, 0);
    step();
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200 || out_result !== 32'h22) begin miscompares++; $display("FAIL bltu_c got rv=%0b pc=%h res=%h want 1/00000200/00000022", redirect_valid, redirect_pc, out_result); end
    drive(1, 0, 3'b010, 1, 0, 0, 0, 32'h33, 32'h300, 32'h0, 5'd0, 0);
    step();
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h200) begin miscompares++; $display("FAIL f3_010 got rv=%0b pc=%h want 0/00000200", redirect_valid, redirect_pc); end
    drive(1, 0, 3'b101, 0, 1, 0, 0, 32'h44, 32'h400, 32'h0, 5'd0, 0);
    step();
    vecs++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL bge_lt got %0b want 0", redirect_valid); end
    drive(1, 0, 3'b001, 0, 0, 0, 0, 32'h55, 32'h500, 32'h0, 5'd0, 0);
    step();
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin miscompares++; $display("FAIL bne got %0b/%h want 1/00000500", redirect_valid, redirect_pc); end
    drive(1, 0, 3'b111, 0, 0, 1, 0, 32'h66, 32'h600, 32'h0, 5'd0, 0);
    step(); idle();
    vecs++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL bgeu_borrow got %0b want 0", redirect_valid); end
    step();
  endtask

  task automatic test_jal();
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'hdead, 32'h40, 32'h24, 5'd1, 1);
    step();
    vecs++; if (out_result !== 32'h24 || out_reg_write !== 1'b1 || out_rd !== 5'd1) begin miscompares++; $display("FAIL jal_link got res=%h rw=%0b rd=%0d want 00000024/1/1", out_result, out_reg_write, out_rd); end
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin miscompares++; $display("FAIL jal_redirect got %0b/%h want 1/00000040", redirect_valid, redirect_pc); end
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'hdead, 32'h40, 32'h24, 5'd0, 1);
    step(); idle();
    vecs++; if (out_reg_write !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL jal_rd0 got rw=%0b v=%0b want 0/1", out_reg_write, out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hA, 32'h0, 32'h0, 5'd2, 1);
    step();
    vecs++; if (in_ready !== 1'b1 || out_result !== 32'hA) begin miscompares++; $display("FAIL skid_a got rdy=%0b res=%h want 1/0000000a", in_ready, out_result); end
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hB, 32'h0, 32'h0, 5'd3, 1);
    step();
    vecs++; if (in_ready !== 1'b0 || out_result !== 32'hA) begin miscompares++; $display("FAIL skid_b got rdy=%0b res=%h want 0/0000000a", in_ready, out_result); end
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hC, 32'h0, 32'h0, 5'd4, 1);
    step();
    vecs++; if (in_ready !== 1'b0 || out_result !== 32'hA || out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_c_wait got rdy=%0b res=%h v=%0b want 0/0000000a/1", in_ready, out_result, out_valid); end
    out_ready = 1;
    step();
    vecs++; if (out_result !== 32'hB || out_rd !== 5'd3 || in_ready !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL order_b got res=%h rd=%0d rdy=%0b want 0000000b/3/1", out_result, out_rd, in_ready); end
    step(); idle();
    vecs++; if (out_result !== 32'hC || out_valid !== 1'b1) begin miscompares++; $display("FAIL order_c got res=%h v=%0b want 0000000c/1", out_result, out_valid); end
    step();
    vecs++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_empty got %0b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 3'b000, 0, 0, 0, 0, 32'h100 + i, 32'h0, 32'h0, 5'd5, 1);
      step();
      vecs++; if (out_valid !== 1'b1 || out_result !== 32'h100 + i || in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_%0d got v=%0b res=%h rdy=%0b", i, out_valid, out_result, in_ready); end
    end
    idle();
    step();
  endtask

  task automatic test_misalign();
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'h0, 32'h102, 32'h80, 5'd3, 1);
    mem_read = 1; mem_write = 1;
    step();
    vecs++; if (out_misalign !== 1'b1 || out_reg_write !== 1'b0 || out_mem_read !== 1'b0 || out_mem_write !== 1'b0) begin miscompares++; $display("FAIL misalign got mis=%0b rw=%0b mr=%0b mw=%0b want 1/0/0/0", out_misalign, out_reg_write, out_mem_read, out_mem_write); end
    vecs++; if (redirect_valid !== 1'b0) begin miscompares++; $display("FAIL misalign_redirect got %0b want 0", redirect_valid); end
    drive(1, 0, 3'b000, 0, 0, 0, 0, 32'h7, 32'h102, 32'h0, 5'd3, 1);
    mem_read = 1;
    step(); idle();
    vecs++; if (out_misalign !== 1'b0 || out_reg_write !== 1'b1 || out_mem_read !== 1'b1) begin miscompares++; $display("FAIL nottaken_misaligned got mis=%0b rw=%0b mr=%0b want 0/1/1", out_misalign, out_reg_write, out_mem_read); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hA1, 32'h0, 32'h0, 5'd2, 1);
    step();
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hB1, 32'h0, 32'h0, 5'd2, 1);
    step();
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'h0, 32'h300, 32'h4, 5'd1, 1);
    flush = 1;
    step(); idle();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_valid !== 1'b0) begin miscompares++; $display("FAIL flush_full got v=%0b rdy=%0b rv=%0b want 0/1/0", out_valid, in_ready, redirect_valid); end
    drive(0, 0, 3'b000, 0, 0, 0, 0, 32'hA2, 32'h0, 32'h0, 5'd2, 1);
    step();
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'h0, 32'h340, 32'h4, 5'd1, 1);
    flush = 1;
    step(); idle();
    vecs++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_accept got v=%0b rv=%0b rdy=%0b want 0/0/1", out_valid, redirect_valid, in_ready); end
    out_ready = 1;
    step();
  endtask

  task automatic test_async_reset();
    drive(0, 1, 3'b000, 0, 0, 0, 0, 32'h0, 32'h800, 32'h44, 5'd6, 1);
    step(); idle();
    vecs++; if (redirect_valid !== 1'b1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset got rv=%0b v=%0b want 1/1", redirect_valid, out_valid); end
    #2 rst_n = 0;
    #1;
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset got rv=%0b pc=%h v=%0b rdy=%0b want 0/0/0/1", redirect_valid, redirect_pc, out_valid, in_ready); end
    vecs++; if (out_result !== 32'h0 || out_reg_write !== 1'b0 || out_rd !== 5'd0) begin miscompares++; $display("FAIL async_reset_data got res=%h rw=%0b rd=%0d want zeros", out_result, out_reg_write, out_rd); end
    #1 rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_cond();
    test_jal();
    test_back_to_back();
    test_misalign();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
